uart_rx_frame_engine: RTL and testbench
=======================================

# uart_rx_frame_engine

Parametrised UART receiver that supersedes the fixed 8-bit receive path with a single self-contained frame engine. It supports configurable data width, optional parity, one or two stop bits, majority-of-3 oversampled bit decisions, break detection, and a resynchronising wait after line faults. It sits in the UART RX clock domain and feeds the RX data synchronizer and the system controller. `RX_IN` is already synchronised to `CLK` upstream.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `PRESC_W`, default 6: width of the `Prescale` input.
- `CLK` in 1: UART RX clock, rising-edge.
- `RST` in 1: synchronous, active-high reset.
- `RX_IN` in 1: serial line, idle high.
- `Prescale` in `PRESC_W`: oversampling ratio; legal values 8, 16, 32.
- `PAR_EN` in 1: parity bit present.
- `PAR_TYPE` in 1: 0 = even, 1 = odd.
- `STOP2` in 1: 1 = two stop bits.
- `P_DATA` out `DATA_WIDTH`: received data, LSB first on the line. Held until the next good frame.
- `data_valid` out 1: one-cycle pulse marking a good frame.
- `par_err` out 1: parity error of the last completed frame.
- `stp_err` out 1: stop error of the last completed frame.
- `brk_det` out 1: one-cycle pulse marking a break frame.
- `busy` out 1: high while in any state other than IDLE.

## Operation
- **Configuration latch.** `Prescale`, `PAR_EN`, `PAR_TYPE` and `STOP2` are latched on start detection. Changes mid-frame are ignored.
- **Bit timing.**
  - `edge_cnt` counts 0..Prescale−1 and wraps.
  - `bit_cnt` advances on wrap.
  - Frame length N = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 bits.
- **Sampling.**
  - Samples are taken at `edge_cnt` = P/2−1, P/2 and P/2+1, where P = latched Prescale.
  - The bit value is the majority of the 3 samples and is valid from `edge_cnt` = P/2+2.
- **States:**
  - **IDLE:** on `RX_IN`=0 → START. In that cycle, clear `par_err`/`stp_err` and latch the configuration.
  - **START:** sample the start bit.
    - Majority 1 (glitch) → IDLE at `edge_cnt` = P/2+2, with no output activity.
    - Otherwise → DATA at wrap.
  - **DATA:** shift each bit into a `DATA_WIDTH` shift register, LSB first. After DATA_WIDTH bits → PARITY if `PAR_EN`, else STOP.
  - **PARITY:** compare the sampled bit with the XOR of the data, inverted for odd parity. Record a mismatch internally. → STOP at wrap.
  - **STOP:** sample 1 or 2 stop bits; any 0 sample is a stop error. At the final wrap → DONE.
  - **DONE (1 cycle):**
    - Update `par_err`/`stp_err`.
    - Break: all data bits 0, parity bit (if present) 0, and stop error. Then `brk_det`=1, `stp_err`=1, no `data_valid`, `P_DATA` unchanged.
    - Good frame (no errors): `P_DATA` ← shift register and `data_valid`=1.
    - Any error: `P_DATA` unchanged.
    - Next state: stop error → WAIT_IDLE; otherwise → IDLE.
  - **WAIT_IDLE:** hold until `RX_IN`=1 for P consecutive cycles, then → IDLE. A low level restarts the count. A new start is never accepted while in this state.
- **Back-to-back frames:** from IDLE, a start edge on the cycle immediately after DONE is accepted.

## Timing
- **t0:** the cycle in which IDLE sees `RX_IN`=0.
- **Start bit:** `edge_cnt`=0 in cycle t0+1. The start bit spans t0+1..t0+P.
- **Frame end:** the last stop bit ends at t0+N·P. DONE is cycle t0+N·P+1, in which `data_valid`/`brk_det` are high and `par_err`/`stp_err`/`P_DATA` become valid.
- **Error flags:** `par_err`/`stp_err` hold from DONE until cleared at the next t0.
- **`busy`:** high from t0+1 through DONE (and WAIT_IDLE); low in IDLE.
- **Reset:** when `RST`=1 at an edge, the next cycle shows:
  - state IDLE, counters 0;
  - `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, `brk_det`=0, `busy`=0.
  - This applies mid-frame too; the partial frame is discarded.
- **Illegal `Prescale`:** behaviour is undefined and is not checked.

## Test plan
- **Good frame with parity.** DATA_WIDTH=8, P=8, PAR_EN=1, even parity, STOP2=0; send 0xA5 with parity 0. Required: N=11, `data_valid` a single pulse at t0+89, `P_DATA`=0xA5, `par_err`=`stp_err`=0.
- **Odd parity, wrong bit.** Same frame with PAR_TYPE=1 and parity bit 0. Required: `par_err`=1 at t0+89, no `data_valid`, `P_DATA` keeps its previous value.
- **Start glitch and noise.**
  - Glitch: `RX_IN` low for 3 cycles, P=16. Required: return to IDLE, `busy` low by t0+11, no outputs.
  - Noise: a single-cycle flip at the centre sample of one data bit. Required: the byte is still received correctly.
- **Break.** `RX_IN` held low for 40 bit times, P=8, no parity. Required: `brk_det` and `stp_err` pulse at t0+81. A new start edge while `RX_IN` is still low is ignored. A valid frame is received only after 8 high cycles.
- **Two stop bits.** DATA_WIDTH=7, STOP2=1, P=32; send 0x55. Required: `data_valid` at t0+321 (N=10). A 0 in the second stop bit → `stp_err`=1.
- **Reset and back-to-back.**
  - Reset: assert `RST` mid-DATA. Required: all outputs 0 next cycle, and the next full frame is received correctly.
  - Back-to-back: two frames with no idle gap. Required: two `data_valid` pulses exactly N·P+1 cycles apart.

Source files
------------

// File: rtl/uart_rx_frame_engine.sv
// Oversampling UART receive frame engine: configurable width, optional parity, 1/2 stop bits,
// majority-of-3 bit decisions, break detection and a resync wait after line faults.
module uart_rx_frame_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYPE,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  brk_det,
  output logic                  busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;

  localparam logic [3:0]         LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [PRESC_W-1:0] ONE      = PRESC_W'(1);

  logic [2:0]            state;
  logic [PRESC_W-1:0]    edge_cnt, p_lat, half;
  logic [3:0]            bit_cnt;
  logic                  pen_lat, ptype_lat, stop2_lat;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  s0, s1, par_bit, par_bad, stop_bad;
  logic                  maj, wrap, at_dec, start_det, brk, last_stop;

  assign half      = p_lat >> 1;
  assign wrap      = (edge_cnt == p_lat - ONE);
  assign at_dec    = (edge_cnt == half + ONE);
  // third sample is the live line, so the decision lands on the same edge it is taken
  assign maj       = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
  // DONE behaves like IDLE for a clean frame so a gapless next start is not lost
  assign start_det = !RX_IN && (state == S_IDLE || (state == S_DONE && !stop_bad));
  assign brk       = stop_bad && (shreg == '0) && !(pen_lat && par_bit);
  assign last_stop = (bit_cnt == {3'b000, stop2_lat});
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_lat      <= '0;
      pen_lat    <= 1'b0;
      ptype_lat  <= 1'b0;
      stop2_lat  <= 1'b0;
      shreg      <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      par_bit    <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      brk_det    <= 1'b0;
      if (edge_cnt == half - ONE) s0 <= RX_IN;
      if (edge_cnt == half)       s1 <= RX_IN;
      case (state)
        S_IDLE, S_DONE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (start_det) begin
            state     <= S_START;
            p_lat     <= Prescale;
            pen_lat   <= PAR_EN;
            ptype_lat <= PAR_TYPE;
            stop2_lat <= STOP2;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            par_bit   <= 1'b0;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
          end else if (state == S_DONE) begin
            state <= stop_bad ? S_WAIT : S_IDLE;
          end
        end
        S_START: begin
          edge_cnt <= wrap ? '0 : edge_cnt + ONE;
          if (at_dec && maj) begin
            state    <= S_IDLE;
            edge_cnt <= '0;
          end else if (wrap) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          edge_cnt <= wrap ? '0 : edge_cnt + ONE;
          if (at_dec) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          if (wrap) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= pen_lat ? S_PAR : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PAR: begin
          edge_cnt <= wrap ? '0 : edge_cnt + ONE;
          if (at_dec) begin
            par_bit <= maj;
            par_bad <= (maj != ((^shreg) ^ ptype_lat));
          end
          if (wrap) state <= S_STOP;
        end
        S_STOP: begin
          edge_cnt <= wrap ? '0 : edge_cnt + ONE;
          if (at_dec && !maj) stop_bad <= 1'b1;
          if (wrap) begin
            if (last_stop) begin
              state   <= S_DONE;
              par_err <= par_bad;
              stp_err <= stop_bad;
              brk_det <= brk;
              if (!par_bad && !stop_bad) begin
                data_valid <= 1'b1;
                P_DATA     <= shreg;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_WAIT: begin
          // edge_cnt doubles as the run length of consecutive idle-high cycles
          if (!RX_IN) begin
            edge_cnt <= '0;
          end else if (edge_cnt == p_lat - ONE) begin
            edge_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            edge_cnt <= edge_cnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Directed + randomized bench for uart_rx_frame_engine; 8-bit and 7-bit instances share config.
module tb_uart_rx_frame_engine;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0, PAR_TYPE = 1'b0, STOP2 = 1'b0;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, se8, brk8, busy8;
  logic       dv7, pe7, se7, brk7, busy7;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, dv8_n = 0, dv7_n = 0, brk8_n = 0, brk7_n = 0, dv8_t = 0, dv8_tp = 0;
  logic       sel7 = 1'b0;
  logic [8:0] exp_pd8 = '0, exp_pd7 = '0;
  logic [8:0] o_pd;
  logic       o_dv, o_pe, o_se, o_brk, o_busy;

  uart_rx_frame_engine #(.DATA_WIDTH(8), .PRESC_W(6)) u8 (
    .CLK(CLK), .RST(RST), .RX_IN(rx8), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYPE(PAR_TYPE), .STOP2(STOP2), .P_DATA(pd8), .data_valid(dv8),
    .par_err(pe8), .stp_err(se8), .brk_det(brk8), .busy(busy8));

  uart_rx_frame_engine #(.DATA_WIDTH(7), .PRESC_W(6)) u7 (
    .CLK(CLK), .RST(RST), .RX_IN(rx7), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYPE(PAR_TYPE), .STOP2(STOP2), .P_DATA(pd7), .data_valid(dv7),
    .par_err(pe7), .stp_err(se7), .brk_det(brk7), .busy(busy7));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dv8) begin dv8_n <= dv8_n + 1; dv8_tp <= dv8_t; dv8_t <= cyc; end
    if (dv7) dv7_n <= dv7_n + 1;
    if (brk8) brk8_n <= brk8_n + 1;
    if (brk7) brk7_n <= brk7_n + 1;
  end

  always_comb begin
    o_pd   = sel7 ? {2'b00, pd7} : {1'b0, pd8};
    o_dv   = sel7 ? dv7   : dv8;
    o_pe   = sel7 ? pe7   : pe8;
    o_se   = sel7 ? se7   : se8;
    o_brk  = sel7 ? brk7  : brk8;
    o_busy = sel7 ? busy7 : busy8;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_rx(input logic v);
    if (sel7) rx7 = v; else rx8 = v;
  endtask

  // line bit k occupies P cycles starting at t0 + k*P; config is scrambled once it has been latched
  task automatic drive_frame(input logic [8:0] dm, input int w, input int p, input logic pen,
                             input logic ptype, input logic pbit, input logic s0b, input logic s1b,
                             input logic s2, input int noise);
    logic q[$];
    logic b;
    q.push_back(1'b0);
    for (int i = 0; i < w; i++) q.push_back(dm[i]);
    if (pen) q.push_back(pbit);
    q.push_back(s0b);
    if (s2) q.push_back(s1b);
    Prescale = 6'(p); PAR_EN = pen; PAR_TYPE = ptype; STOP2 = s2;
    for (int k = 0; k < q.size(); k++) begin
      for (int e = 0; e < p; e++) begin
        if (k == 0 && e == 2) begin
          Prescale = (p == 8) ? 6'd16 : 6'd8;
          PAR_EN = ~pen; PAR_TYPE = ~ptype; STOP2 = ~s2;
        end
        b = q[k];
        if (k == noise && e == p / 2 + 1) b = ~b;
        set_rx(b);
        tick();
      end
    end
  endtask

  task automatic frame(input logic [8:0] d, input int p, input logic pen, input logic ptype,
                       input logic pflip, input logic s0b, input logic s1b, input logic s2,
                       input int noise, input string tag);
    int w, n0, b0;
    logic [8:0] dm;
    logic pbit, pe, se, brk, good;
    w    = sel7 ? 7 : 8;
    dm   = d & ((9'd1 << w) - 9'd1);
    pbit = (^dm) ^ ptype ^ pflip;
    n0   = sel7 ? dv7_n : dv8_n;
    b0   = sel7 ? brk7_n : brk8_n;
    drive_frame(dm, w, p, pen, ptype, pbit, s0b, s1b, s2, noise);
    set_rx(1'b1);
    chk({tag, " dv early"}, o_dv, 0);
    tick();
    // reference: even parity => data+parity has an even number of ones
    pe   = pen && ((^{dm, pbit}) != ptype);
    se   = !s0b || (s2 && !s1b);
    brk  = se && (dm == 9'd0) && !(pen && pbit);
    good = !pe && !se;
    if (good) begin
      if (sel7) exp_pd7 = dm; else exp_pd8 = dm;
    end
    chk({tag, " dv"},  o_dv,  good);
    chk({tag, " brk"}, o_brk, brk);
    chk({tag, " par"}, o_pe,  pe);
    chk({tag, " stp"}, o_se,  se);
    chk({tag, " pd"},  o_pd,  sel7 ? exp_pd7 : exp_pd8);
    tick();
    chk({tag, " dv count"},  (sel7 ? dv7_n : dv8_n) - n0,   good ? 1 : 0);
    chk({tag, " brk count"}, (sel7 ? brk7_n : brk8_n) - b0, brk ? 1 : 0);
    repeat (p + 2) tick();
  endtask

  initial begin
    int t0, n0, b0, p;
    logic [8:0] d, d2;

    repeat (2) tick();
    RST = 1'b0;
    chk("rst pd", pd8, 0);
    chk("rst dv", dv8, 0);
    chk("rst par", pe8, 0);
    chk("rst stp", se8, 0);
    chk("rst brk", brk8, 0);
    chk("rst busy", busy8, 0);
    repeat (3) tick();

    frame(9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, "good_a5");
    d = 9'($urandom_range(1, 255));
    if (d == 9'h0A5) d = 9'h05A;
    frame(d, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, "good_rand");
    frame(9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, "odd_bad");

    // start glitch: line low for three cycles only
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYPE = 1'b0; STOP2 = 1'b0;
    n0 = dv8_n; b0 = brk8_n;
    chk("glitch par before", pe8, 1);
    rx8 = 1'b0; t0 = cyc;
    tick();
    chk("glitch busy t0+1", busy8, 1);
    chk("glitch par cleared", pe8, 0);
    tick(); tick();
    rx8 = 1'b1;
    while (cyc < t0 + 10) tick();
    chk("glitch busy t0+10", busy8, 1);
    tick();
    chk("glitch busy t0+11", busy8, 0);
    repeat (20) tick();
    chk("glitch no dv", dv8_n - n0, 0);
    chk("glitch no brk", brk8_n - b0, 0);
    chk("glitch pd", pd8, exp_pd8);

    d = 9'($urandom_range(0, 255));
    frame(d, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, "noise");

    // break: 40 bit times low at P=8
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYPE = 1'b0; STOP2 = 1'b0;
    n0 = dv8_n; b0 = brk8_n;
    rx8 = 1'b0; t0 = cyc;
    repeat (80) tick();
    chk("brk early", brk8, 0);
    tick();
    chk("brk pulse", brk8, 1);
    chk("brk stp", se8, 1);
    chk("brk dv", dv8, 0);
    chk("brk pd", pd8, exp_pd8);
    while (cyc < t0 + 320) tick();
    chk("brk busy low line", busy8, 1);
    rx8 = 1'b1; repeat (5) tick();
    rx8 = 1'b0; repeat (20) tick();
    chk("brk restart ignored", busy8, 1);
    rx8 = 1'b1; repeat (7) tick();
    chk("brk busy 7 high", busy8, 1);
    tick();
    chk("brk idle 8 high", busy8, 0);
    chk("brk single", brk8_n - b0, 1);
    chk("brk no dv", dv8_n - n0, 0);
    frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, "after_brk");

    sel7 = 1'b1;
    frame(9'h055, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, "stop2_good");
    frame(9'h055, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, "stop2_bad");
    sel7 = 1'b0;

    // reset in the middle of the data bits
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYPE = 1'b0; STOP2 = 1'b0;
    rx8 = 1'b0; repeat (8) tick();
    rx8 = 1'b1; repeat (8) tick();
    rx8 = 1'b0; repeat (3) tick();
    chk("mid busy", busy8, 1);
    rx8 = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_pd8 = '0; exp_pd7 = '0;
    chk("mid rst pd", pd8, 0);
    chk("mid rst dv", dv8, 0);
    chk("mid rst par", pe8, 0);
    chk("mid rst stp", se8, 0);
    chk("mid rst brk", brk8, 0);
    chk("mid rst busy", busy8, 0);
    repeat (4) tick();
    d = 9'($urandom_range(1, 255));
    frame(d, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, "post_rst");

    // back-to-back: second start bit immediately follows the first stop bit on the line
    d = 9'($urandom_range(0, 255)); d2 = 9'($urandom_range(0, 255));
    n0 = dv8_n;
    drive_frame(d, 8, 8, 1'b1, 1'b0, ^d[7:0], 1'b1, 1'b1, 1'b0, -1);
    drive_frame(d2, 8, 8, 1'b1, 1'b0, ^d2[7:0], 1'b1, 1'b1, 1'b0, -1);
    rx8 = 1'b1;
    tick(); tick();
    exp_pd8 = d2;
    chk("b2b dv2", dv8, 1);
    chk("b2b pd", pd8, exp_pd8);
    tick();
    chk("b2b count", dv8_n - n0, 2);
    chk("b2b spacing", dv8_t - dv8_tp, 11 * 8 + 1);
    repeat (10) tick();

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      d = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(0, 255));
      sel7 = $urandom_range(0, 1) == 1;
      frame(d, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1 + $urandom_range(0, 6) : -1,
            "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
